reg_readout_serializer: RTL and testbench

Read-side companion to the 32-bit storage register: on request, snapshots the register's parallel output and streams it out one bit per accepted transfer over a valid/ready serial link. It sits between the register bank's `Q` bus and any narrow consumer (debug port, serial link, test probe). The snapshot is held in a shadow register, so the source register may be rewritten mid-transfer without corrupting the stream.

---
 rtl/reg_readout_pkg.sv | 18 +
 rtl/shift_bit_counter.sv | 34 +++
 rtl/reg_readout_serializer.sv | 103 ++++++++++
 tb/tb_reg_readout_serializer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_readout_pkg.sv
// Shared definitions for the register read-out serializer: FSM states,
// default word width and the bit-index width helper.
package reg_readout_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of the bit index; WIDTH is at least 2, so this is never zero.
    function automatic int idx_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Counts bits accepted in the current word. Cleared on load, saturates at
// WIDTH-1 and flags that terminal value so the FSM knows the last bit is out.
module shift_bit_counter
    import reg_readout_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_clr,
    input  logic                          i_inc,
    output logic [idx_width(WIDTH)-1:0]   o_count,
    output logic                          o_last
);

    localparam int CW = idx_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_last) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == LAST_IDX);

endmodule

// File: rtl/reg_readout_serializer.sv
// Snapshots a parallel register word into a shadow register and streams it
// out one bit per accepted valid/ready transfer.
module reg_readout_serializer
    import reg_readout_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rd_req,
    input  logic [WIDTH-1:0]              rd_data,
    output logic                          rd_ack,
    output logic                          busy,
    output logic                          sout,
    output logic                          sout_valid,
    input  logic                          sout_ready,
    output logic [idx_width(WIDTH)-1:0]   bit_idx,
    output logic                          done
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shadow;
    logic             r_rd_ack;
    logic             w_load;
    logic             w_xfer;
    logic             w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rd_req) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sout_ready) begin
                    w_xfer = 1'b1;
                    if (w_last) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Zero fill means the shadow is all zeros once a word has fully drained,
    // so sout can be taken straight from the output end in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_rd_ack <= 1'b0;
        end else begin
            r_rd_ack <= w_load;
            if (w_load) begin
                r_shadow <= rd_data;
            end else if (w_xfer) begin
                if (MSB_FIRST) begin
                    r_shadow <= {r_shadow[WIDTH-2:0], 1'b0};
                end else begin
                    r_shadow <= {1'b0, r_shadow[WIDTH-1:1]};
                end
            end
        end
    end

    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_load),
        .i_inc   (w_xfer),
        .o_count (bit_idx),
        .o_last  (w_last)
    );

    assign rd_ack     = r_rd_ack;
    assign busy       = (r_state != ST_IDLE);
    assign sout_valid = (r_state == ST_SHIFT);
    assign done       = (r_state == ST_DONE);
    assign sout       = MSB_FIRST ? r_shadow[WIDTH-1] : r_shadow[0];

endmodule

// File: tb/tb_reg_readout_serializer.sv
// Bench for reg_readout_serializer: two instances (MSB-first and LSB-first)
// share stimulus; a word-level scoreboard predicts every cycle's outputs.
module tb_reg_readout_serializer;

    localparam int W  = 32;
    localparam int CW = $clog2(W);

    logic          clk;
    logic          reset;
    logic          rd_req;
    logic [W-1:0]  rd_data;
    logic          sout_ready;

    logic          ack_m, busy_m, sout_m, valid_m, done_m;
    logic [CW-1:0] idx_m;
    logic          ack_l, busy_l, sout_l, valid_l, done_l;
    logic [CW-1:0] idx_l;

    reg_readout_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_data(rd_data),
        .rd_ack(ack_m), .busy(busy_m), .sout(sout_m), .sout_valid(valid_m),
        .sout_ready(sout_ready), .bit_idx(idx_m), .done(done_m)
    );

    reg_readout_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_data(rd_data),
        .rd_ack(ack_l), .busy(busy_l), .sout(sout_l), .sout_valid(valid_l),
        .sout_ready(sout_ready), .bit_idx(idx_l), .done(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard: the word in flight (at most one), how many of its bits the
    // consumer has taken, and the expected one-cycle pulses for this cycle.
    logic [W-1:0] sb_q[$];
    int           acc        = 0;
    int           hold_idx   = 0;
    bit           exp_done   = 1'b0;
    bit           exp_ack    = 1'b0;
    bit           seen_reset = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [W-1:0] w;
        bit           v;
        bit           idle_now;
        v = (sb_q.size() != 0);
        if (seen_reset) begin
            chk("valid_msb", 32'(valid_m), 32'(v));
            chk("valid_lsb", 32'(valid_l), 32'(v));
            chk("busy_msb",  32'(busy_m),  32'(v || exp_done));
            chk("busy_lsb",  32'(busy_l),  32'(v || exp_done));
            chk("done_msb",  32'(done_m),  32'(exp_done));
            chk("done_lsb",  32'(done_l),  32'(exp_done));
            chk("ack_msb",   32'(ack_m),   32'(exp_ack));
            chk("ack_lsb",   32'(ack_l),   32'(exp_ack));
            if (v) begin
                w = sb_q[0];
                chk("sout_msb", 32'(sout_m), 32'(w[W-1-acc]));
                chk("sout_lsb", 32'(sout_l), 32'(w[acc]));
                chk("idx_msb",  32'(idx_m),  32'(acc));
                chk("idx_lsb",  32'(idx_l),  32'(acc));
            end else begin
                chk("sout_idle_msb", 32'(sout_m), 32'(0));
                chk("sout_idle_lsb", 32'(sout_l), 32'(0));
                chk("idx_idle_msb",  32'(idx_m),  32'(hold_idx));
                chk("idx_idle_lsb",  32'(idx_l),  32'(hold_idx));
            end
        end
        idle_now = !v && !exp_done;
        if (reset) begin
            sb_q.delete();
            acc        = 0;
            hold_idx   = 0;
            exp_done   = 1'b0;
            exp_ack    = 1'b0;
            seen_reset = 1'b1;
        end else begin
            exp_done = 1'b0;
            exp_ack  = 1'b0;
            if (v && sout_ready) begin
                if (acc == W - 1) begin
                    void'(sb_q.pop_front());
                    exp_done = 1'b1;
                    hold_idx = W - 1;
                    acc      = 0;
                end else begin
                    acc++;
                end
            end
            if (idle_now && rd_req) begin
                sb_q.push_back(rd_data);
                exp_ack = 1'b1;
                acc     = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sb_q.size() != 0 || exp_done) && k < 2000) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (k >= 2000) begin
            n_err++;
            $display("FAIL idle_timeout: waited %0d cycles, required idle within 2000", k);
        end
    endtask

    task automatic issue(input logic [W-1:0] word);
        wait_idle();
        rd_data = word;
        rd_req  = 1'b1;
        tick(1);
        rd_req  = 1'b0;
    endtask

    initial begin
        int k;
        reset      = 1'b1;
        rd_req     = 1'b1;
        rd_data    = 32'hFFFF_FFFF;
        sout_ready = 1'b1;

        // Reset with a pending request, then the all-ones word.
        tick(2);
        reset = 1'b0;
        tick(1);
        rd_req = 1'b0;
        wait_idle();
        tick(2);

        // Snapshot isolation: source word changes two cycles after load.
        issue(32'h8000_0801);
        tick(1);
        rd_data = 32'hAAAA_AAAA;
        wait_idle();

        // LSB/MSB streams with a consumer ready every other cycle.
        issue(32'h0000_0005);
        k = 0;
        while ((sb_q.size() != 0 || exp_done) && k < 500) begin
            sout_ready = ~sout_ready;
            tick(1);
            k++;
        end
        sout_ready = 1'b1;
        wait_idle();

        // Requests during SHIFT and DONE are ignored.
        issue($urandom);
        tick(5);
        rd_data = $urandom;
        rd_req  = 1'b1;
        tick(1);
        rd_req  = 1'b0;
        k = 0;
        while (!exp_done && k < 100) begin
            tick(1);
            k++;
        end
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
        tick(2);

        // Request held high across a whole word: reload on first IDLE cycle.
        wait_idle();
        rd_data = 32'h1234_5678;
        rd_req  = 1'b1;
        tick(40);
        rd_req  = 1'b0;
        wait_idle();

        // Abort after ten accepted bits, then a fresh word.
        issue(32'hDEAD_BEEF);
        tick(10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        issue(32'h0000_000F);
        wait_idle();

        // Randomised traffic: request, data, backpressure and rare resets.
        for (int i = 0; i < 3000; i++) begin
            rd_data    = $urandom;
            rd_req     = ($urandom_range(0, 3) == 0);
            sout_ready = ($urandom_range(0, 3) != 0);
            reset      = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        reset      = 1'b0;
        rd_req     = 1'b0;
        sout_ready = 1'b1;
        wait_idle();
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
